scarv_cop_insn_buf: RTL and testbench
=====================================

Name: scarv_cop_insn_buf

Overview:
- Upstream neighbour of the ISE instruction decoder.
- Queues coprocessor instructions and their rs1 GPR value from the host CPU.
- Presents the head instruction word to the decoder on id_encoded and issues decoded-legal instructions to the execute stage, one at a time.
- Returns exactly one in-order response per accepted instruction to the CPU.

Parameters:
- DEPTH, 4, instruction queue entries; power of two, >= 2.
- CW, 3, width of occupancy count; equals clog2(DEPTH+1).

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous active-high reset
- cpu_insn_req  in  1  CPU offers instruction
- cpu_insn_ack  out  1  buffer accepts; transfer when req && ack
- cpu_insn_enc  in  32  instruction encoding
- cpu_rs1  in  32  rs1 GPR value
- cpu_rsp_valid  out  1  response valid
- cpu_rsp_ready  in  1  CPU consumes response
- cpu_rsp_result  out  3  result code
- cpu_rsp_wen  out  1  write rd
- cpu_rsp_wdata  out  32  rd write data
- id_encoded  out  32  head instruction to decoder
- id_exception  in  1  decoder illegal-instruction flag for id_encoded
- dispatch_valid  out  1  head issued to execute
- dispatch_ready  in  1  execute accepts
- dispatch_rs1  out  32  rs1 value of head
- exec_done  in  1  execute completes in-flight instruction (1-cycle pulse)
- exec_result  in  3  execute result code
- exec_wen  in  1  execute rd write enable
- exec_wdata  in  32  execute rd data
- buf_count  out  CW  queued entries, excluding in-flight

Behaviour:
Reset:
- Queue pointers and count = 0; state = S_ISSUE.
- cpu_rsp_valid, cpu_rsp_wen = 0; cpu_rsp_result, cpu_rsp_wdata = 0.
- Reset mid-operation discards queued, in-flight and pending-response instructions. No response is generated for any of them.

Queue:
- cpu_insn_ack = (count < DEPTH). It does not depend on cpu_insn_req or a same-cycle pop, so there is no pass-through when full.
- A push in cycle N makes the entry visible at the head in N+1 when the queue was empty.
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.
- id_encoded = head encoding when count > 0, else 32'h0.
- dispatch_rs1 = head rs1 when count > 0, else 0.
- Head is stable until popped.

FSM, state encodings as shared constants:
- S_ISSUE:
  - dispatch_valid = (count > 0) && !id_exception.
  - If count > 0 && id_exception: pop; load response {result = SCARV_COP_INSN_BAD_INS, wen = 0, wdata = 0}; go to S_RESP. dispatch_valid stays 0.
  - Else if dispatch_valid && dispatch_ready: pop; go to S_EXEC.
  - Else stay.
- S_EXEC:
  - dispatch_valid = 0.
  - On exec_done: register exec_result, exec_wen, exec_wdata into the response; go to S_RESP.
- S_RESP:
  - cpu_rsp_valid = 1; response fields held stable.
  - On cpu_rsp_ready: cpu_rsp_valid drops next cycle; go to S_ISSUE.

Protocol rules:
- exec_done outside S_EXEC is ignored.
- At most one instruction is in flight; responses are strictly in acceptance order.
- Minimum turnaround per legal instruction: dispatch cycle, exec_done cycle, response cycle (with zero-latency execute and an always-ready CPU).
- Queue accepts pushes in every state while not full.

Decomposition:
- In scarv_cop_common.vh:
  - result codes SCARV_COP_INSN_SUCCESS = 3'b000, SCARV_COP_INSN_ABORT = 3'b001, SCARV_COP_INSN_BAD_INS = 3'b010;
  - FSM state constants S_ISSUE, S_EXEC, S_RESP.
- Sub-module scarv_cop_insn_fifo: generic synchronous FIFO.
  - Parameters: WIDTH = 64, DEPTH.
  - Ports: push, pop, full, empty, count, head data.
  - Instantiated once, storing {cpu_rs1, cpu_insn_enc}.

Test Plan:
- Reset then single push enc=32'h1234_5677, rs1=32'hA5 with decoder model legal, dispatch_ready=1, exec_done 2 cycles later with {SUCCESS, wen=1, wdata=32'hDEAD_BEEF} -> id_encoded=32'h1234_5677 cycle after push; dispatch_rs1=32'hA5; one response {000, 1, 32'hDEAD_BEEF}; buf_count returns to 0.
- Push while id_exception=1 -> no dispatch_valid; response {010, 0, 0} next cycle; head popped.
- DEPTH=4, dispatch_ready=0, push 5 back-to-back -> 4 accepted; cpu_insn_ack=0 while count=4; count=4; 5th req held; after one dispatch, ack rises and 5th accepted.
- Hold cpu_rsp_ready=0 for 10 cycles in S_RESP -> response fields stable; no further dispatch; queue still accepts pushes; exec_done pulses ignored.
- 3 queued instructions, assert g_reset during S_EXEC -> next cycle: count=0, cpu_rsp_valid=0, dispatch_valid=0; later exec_done produces no response.
- Interleaved push/pop at count=2 over 8 pointer wraps -> count constant; responses in push order with matching rs1/encoding.

Source files
------------

// File: rtl/scarv_cop_insn_buf_pkg.sv
//------------------------------------------------------------------------------
// Module   : scarv_cop_insn_buf_pkg
// Purpose  : Shared result codes, FSM states and response record for the
//            coprocessor instruction buffer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package scarv_cop_insn_buf_pkg;

    localparam logic [2:0] SCARV_COP_INSN_SUCCESS = 3'b000;
    localparam logic [2:0] SCARV_COP_INSN_ABORT   = 3'b001;
    localparam logic [2:0] SCARV_COP_INSN_BAD_INS = 3'b010;

    typedef enum logic [1:0] {
        S_ISSUE = 2'b00,
        S_EXEC  = 2'b01,
        S_RESP  = 2'b10
    } insn_buf_state_t;

    typedef struct packed {
        logic [2:0]  result;
        logic        wen;
        logic [31:0] wdata;
    } insn_rsp_t;

endpackage

`default_nettype wire

// File: rtl/scarv_cop_insn_fifo.sv
//------------------------------------------------------------------------------
// Module   : scarv_cop_insn_fifo
// Purpose  : Generic synchronous FIFO with occupancy count and head data.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scarv_cop_insn_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/scarv_cop_insn_buf.sv
//------------------------------------------------------------------------------
// Module   : scarv_cop_insn_buf
// Purpose  : Queues CPU coprocessor instructions, issues them one at a time to
//            execute and returns one in-order response per instruction.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scarv_cop_insn_buf
    import scarv_cop_insn_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          g_clk,
    input  logic          g_reset,

    input  logic          cpu_insn_req,
    output logic          cpu_insn_ack,
    input  logic [31:0]   cpu_insn_enc,
    input  logic [31:0]   cpu_rs1,

    output logic          cpu_rsp_valid,
    input  logic          cpu_rsp_ready,
    output logic [2:0]    cpu_rsp_result,
    output logic          cpu_rsp_wen,
    output logic [31:0]   cpu_rsp_wdata,

    output logic [31:0]   id_encoded,
    input  logic          id_exception,

    output logic          dispatch_valid,
    input  logic          dispatch_ready,
    output logic [31:0]   dispatch_rs1,

    input  logic          exec_done,
    input  logic [2:0]    exec_result,
    input  logic          exec_wen,
    input  logic [31:0]   exec_wdata,

    output logic [CW-1:0] buf_count
);

    insn_buf_state_t r_state;
    insn_rsp_t       r_rsp;
    logic            r_rsp_valid;

    logic            w_full;
    logic            w_empty;
    logic            w_nonempty;
    logic            w_push;
    logic            w_pop;
    logic            w_in_issue;
    logic            w_take_bad;
    logic [63:0]     w_head;

    scarv_cop_insn_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (g_clk),
        .rst       (g_reset),
        .push      (w_push),
        .push_data ({cpu_rs1, cpu_insn_enc}),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .count     (buf_count),
        .head_data (w_head)
    );

    // Acceptance depends only on occupancy: no pass-through when full.
    assign cpu_insn_ack = !w_full;
    assign w_push       = cpu_insn_req && cpu_insn_ack;
    assign w_nonempty   = !w_empty;

    assign id_encoded   = w_nonempty ? w_head[31:0]  : 32'h0;
    assign dispatch_rs1 = w_nonempty ? w_head[63:32] : 32'h0;

    assign w_in_issue     = (r_state == S_ISSUE);
    assign w_take_bad     = w_in_issue && w_nonempty && id_exception;
    assign dispatch_valid = w_in_issue && w_nonempty && !id_exception;
    assign w_pop          = w_take_bad || (dispatch_valid && dispatch_ready);

    assign cpu_rsp_valid  = r_rsp_valid;
    assign cpu_rsp_result = r_rsp.result;
    assign cpu_rsp_wen    = r_rsp.wen;
    assign cpu_rsp_wdata  = r_rsp.wdata;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state     <= S_ISSUE;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (w_take_bad) begin
                        r_rsp       <= '{result: SCARV_COP_INSN_BAD_INS,
                                         wen:    1'b0,
                                         wdata:  32'h0};
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (dispatch_valid && dispatch_ready) begin
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        r_rsp       <= '{result: exec_result,
                                         wen:    exec_wen,
                                         wdata:  exec_wdata};
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (cpu_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                default: begin
                    r_state     <= S_ISSUE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scarv_cop_insn_buf.sv
//------------------------------------------------------------------------------
// Module   : tb_scarv_cop_insn_buf
// Purpose  : Directed self-checking bench for the coprocessor instruction buffer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_scarv_cop_insn_buf;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        cpu_insn_req;
    logic        cpu_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [2:0]  cpu_rsp_result;
    logic        cpu_rsp_wen;
    logic [31:0] cpu_rsp_wdata;
    logic [31:0] id_encoded;
    logic        id_exception;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [31:0] dispatch_rs1;
    logic        exec_done;
    logic [2:0]  exec_result;
    logic        exec_wen;
    logic [31:0] exec_wdata;
    logic [2:0]  buf_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] enc;
        logic [31:0] rs1;
        logic        illegal;
        int          lat;
        logic [2:0]  x_res;
        logic        x_wen;
        logic [31:0] x_wdata;
        logic [2:0]  e_res;
        logic        e_wen;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] q [$];

    always #5 g_clk = ~g_clk;

    // Decoder model: any encoding with top nibble F is illegal.
    assign id_exception = (id_encoded[31:28] == 4'hF);

    scarv_cop_insn_buf #(.DEPTH(4), .CW(3)) dut (
        .g_clk          (g_clk),
        .g_reset        (g_reset),
        .cpu_insn_req   (cpu_insn_req),
        .cpu_insn_ack   (cpu_insn_ack),
        .cpu_insn_enc   (cpu_insn_enc),
        .cpu_rs1        (cpu_rs1),
        .cpu_rsp_valid  (cpu_rsp_valid),
        .cpu_rsp_ready  (cpu_rsp_ready),
        .cpu_rsp_result (cpu_rsp_result),
        .cpu_rsp_wen    (cpu_rsp_wen),
        .cpu_rsp_wdata  (cpu_rsp_wdata),
        .id_encoded     (id_encoded),
        .id_exception   (id_exception),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_rs1   (dispatch_rs1),
        .exec_done      (exec_done),
        .exec_result    (exec_result),
        .exec_wen       (exec_wen),
        .exec_wdata     (exec_wdata),
        .buf_count      (buf_count)
    );

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] enc, input logic [31:0] rs1);
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        cpu_rs1      = rs1;
        check("push_ack", cpu_insn_ack, 1);
        tick();
        cpu_insn_req = 1'b0;
    endtask

    task automatic finish_exec(input logic [2:0] res, input logic wen, input logic [31:0] wdata);
        exec_done   = 1'b1;
        exec_result = res;
        exec_wen    = wen;
        exec_wdata  = wdata;
        tick();
        exec_done   = 1'b0;
    endtask

    task automatic accept_rsp();
        cpu_rsp_ready = 1'b1;
        tick();
        cpu_rsp_ready = 1'b0;
        check("rsp_drop", cpu_rsp_valid, 0);
    endtask

    // Issue the legal head; execute returns SUCCESS with wdata = enc ^ rs1.
    task automatic drain_one(input logic [31:0] enc, input logic [31:0] rs1);
        check("drain_enc", id_encoded, enc);
        check("drain_rs1", dispatch_rs1, rs1);
        check("drain_dv", dispatch_valid, 1);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        finish_exec(3'b000, 1'b1, enc ^ rs1);
        check("drain_rsp_v", cpu_rsp_valid, 1);
        check("drain_rsp_res", cpu_rsp_result, 3'b000);
        check("drain_rsp_wd", cpu_rsp_wdata, enc ^ rs1);
        accept_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [63:0] e;
        logic [31:0] hold_wd;

        vecs[0] = '{32'h1234_5677, 32'h0000_00A5, 1'b0, 1, 3'b000, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{32'hF000_0001, 32'h0000_0055, 1'b1, 0, 3'b000, 1'b0, 32'h0,         3'b010, 1'b0, 32'h0};
        vecs[2] = '{32'h0BAD_0003, 32'h0000_0001, 1'b0, 0, 3'b001, 1'b0, 32'h1111_2222, 3'b001, 1'b0, 32'h1111_2222};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 3'b000, 1'b1, 32'h0,         3'b000, 1'b1, 32'h0};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 3'b000, 1'b0, 32'h0,         3'b010, 1'b0, 32'h0};

        g_reset = 1'b1;
        cpu_insn_req = 1'b0; cpu_insn_enc = '0; cpu_rs1 = '0;
        cpu_rsp_ready = 1'b0; dispatch_ready = 1'b0;
        exec_done = 1'b0; exec_result = '0; exec_wen = 1'b0; exec_wdata = '0;
        repeat (3) tick();
        g_reset = 1'b0;

        check("rst_count", buf_count, 0);
        check("rst_rsp_valid", cpu_rsp_valid, 0);
        check("rst_rsp_result", cpu_rsp_result, 0);
        check("rst_rsp_wen", cpu_rsp_wen, 0);
        check("rst_rsp_wdata", cpu_rsp_wdata, 0);
        check("rst_dv", dispatch_valid, 0);
        check("rst_id_enc", id_encoded, 0);
        check("rst_ack", cpu_insn_ack, 1);

        // Table-driven single transactions.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            push_one(v.enc, v.rs1);
            check("vec_id_enc", id_encoded, v.enc);
            check("vec_rs1", dispatch_rs1, v.rs1);
            check("vec_count1", buf_count, 1);
            if (v.illegal) begin
                check("vec_dv_bad", dispatch_valid, 0);
                tick();
            end else begin
                check("vec_dv", dispatch_valid, 1);
                dispatch_ready = 1'b1;
                tick();
                dispatch_ready = 1'b0;
                check("vec_dv_exec", dispatch_valid, 0);
                for (int k = 0; k < v.lat; k++) begin
                    tick();
                    check("vec_no_rsp", cpu_rsp_valid, 0);
                end
                finish_exec(v.x_res, v.x_wen, v.x_wdata);
            end
            check("vec_rsp_valid", cpu_rsp_valid, 1);
            check("vec_rsp_result", cpu_rsp_result, v.e_res);
            check("vec_rsp_wen", cpu_rsp_wen, v.e_wen);
            check("vec_rsp_wdata", cpu_rsp_wdata, v.e_wdata);
            check("vec_count0", buf_count, 0);
            accept_rsp();
        end

        // Fill to DEPTH with execute stalled; fifth request held until a pop.
        for (int i = 0; i < 5; i++) begin
            cpu_insn_req = 1'b1;
            cpu_insn_enc = 32'h0200_0000 + i;
            cpu_rs1      = 32'h100 + i;
            check("full_ack", cpu_insn_ack, (i < 4) ? 1 : 0);
            check("full_count", buf_count, i);
            if (i < 4) tick();
        end
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        check("full_ack_reopen", cpu_insn_ack, 1);
        check("full_count_pop", buf_count, 3);
        tick();
        cpu_insn_req = 1'b0;
        check("full_count_refill", buf_count, 4);
        finish_exec(3'b000, 1'b1, 32'h0200_0000 ^ 32'h100);
        check("full_rsp0", cpu_rsp_wdata, 32'h0200_0100);
        accept_rsp();
        for (int i = 1; i < 5; i++) drain_one(32'h0200_0000 + i, 32'h100 + i);

        // Response back-pressure: fields stable, pushes accepted, exec_done ignored.
        push_one(32'h0300_0000, 32'h30);
        push_one(32'h0300_0001, 32'h31);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        finish_exec(3'b001, 1'b1, 32'hCAFE_0000);
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", cpu_rsp_valid, 1);
            check("stall_res", cpu_rsp_result, 3'b001);
            check("stall_wd", cpu_rsp_wdata, 32'hCAFE_0000);
            check("stall_dv", dispatch_valid, 0);
            if (c == 2 || c == 5) begin
                cpu_insn_req = 1'b1;
                cpu_insn_enc = (c == 2) ? 32'h0300_0002 : 32'h0300_0003;
                cpu_rs1      = (c == 2) ? 32'h32 : 32'h33;
            end
            if (c % 2 == 1) begin
                exec_done = 1'b1; exec_result = 3'b000; exec_wen = 1'b0;
                exec_wdata = 32'h5555_0000 + c;
            end
            tick();
            cpu_insn_req = 1'b0;
            exec_done = 1'b0;
        end
        check("stall_count", buf_count, 3);
        accept_rsp();
        for (int i = 1; i < 4; i++) drain_one(32'h0300_0000 + i, 32'h30 + i);

        // Reset while an instruction is in flight.
        for (int i = 0; i < 3; i++) push_one(32'h0400_0000 + i, 32'h40 + i);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        check("rstx_count_pre", buf_count, 2);
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        check("rstx_count", buf_count, 0);
        check("rstx_rsp_valid", cpu_rsp_valid, 0);
        check("rstx_dv", dispatch_valid, 0);
        check("rstx_id_enc", id_encoded, 0);
        finish_exec(3'b000, 1'b1, 32'hBAD0_BAD0);
        for (int k = 0; k < 3; k++) begin
            check("rstx_no_rsp", cpu_rsp_valid, 0);
            tick();
        end

        // Steady occupancy of two with a push on every pop, across 8 wraps.
        q.delete();
        for (int i = 0; i < 2; i++) begin
            push_one(32'h0500_0000 + i, 32'h5000 + i);
            q.push_back({32'h5000 + i, 32'h0500_0000 + i});
        end
        for (int k = 2; k < 34; k++) begin
            e = q.pop_front();
            check("wrap_enc", id_encoded, e[31:0]);
            check("wrap_rs1", dispatch_rs1, e[63:32]);
            cpu_insn_req   = 1'b1;
            cpu_insn_enc   = 32'h0500_0000 + k;
            cpu_rs1        = 32'h5000 + k * 7;
            dispatch_ready = 1'b1;
            tick();
            cpu_insn_req   = 1'b0;
            dispatch_ready = 1'b0;
            q.push_back({32'h5000 + k * 7, 32'h0500_0000 + k});
            check("wrap_count", buf_count, 2);
            hold_wd = e[31:0] ^ e[63:32];
            finish_exec(3'b000, 1'b1, hold_wd);
            check("wrap_rsp", cpu_rsp_wdata, hold_wd);
            accept_rsp();
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            drain_one(e[31:0], e[63:32]);
        end
        check("end_count", buf_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
